// File: rtl/coef_ramp_pkg.sv
// Shared definitions for the coefficient ramp controller: widths, the
// select-to-coefficient table and the ramp FSM state encoding.
package coef_ramp_pkg;

  localparam int SEL_W  = 3;
  localparam int COEF_W = 8;

  localparam logic [COEF_W-1:0] COEF_0 = 8'd0;
  localparam logic [COEF_W-1:0] COEF_1 = 8'd36;
  localparam logic [COEF_W-1:0] COEF_2 = 8'd73;
  localparam logic [COEF_W-1:0] COEF_3 = 8'd109;
  localparam logic [COEF_W-1:0] COEF_4 = 8'd146;
  localparam logic [COEF_W-1:0] COEF_5 = 8'd182;
  localparam logic [COEF_W-1:0] COEF_6 = 8'd219;
  localparam logic [COEF_W-1:0] COEF_7 = 8'd255;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Maps the operator select to its target coefficient.
  function automatic logic [COEF_W-1:0] coef_lookup(input logic [SEL_W-1:0] sel);
    logic [COEF_W-1:0] value;
    case (sel)
      3'd0:    value = COEF_0;
      3'd1:    value = COEF_1;
      3'd2:    value = COEF_2;
      3'd3:    value = COEF_3;
      3'd4:    value = COEF_4;
      3'd5:    value = COEF_5;
      3'd6:    value = COEF_6;
      default: value = COEF_7;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/coef_slew_step.sv
// One bounded slew step: moves current toward target by at most STEP,
// clamping at the target so the result never overshoots, wraps or underflows.
module coef_slew_step
  import coef_ramp_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [COEF_W-1:0] current_value,
  input  logic [COEF_W-1:0] target_value,
  output logic [COEF_W-1:0] next_value,
  output logic              at_target
);

  localparam logic [COEF_W:0] STEP_EXT = (COEF_W + 1)'(STEP);

  logic [COEF_W:0]        up_sum;
  logic signed [COEF_W:0] down_diff;

  // Saturating step: 9-bit sum for the upward case, signed 9-bit difference
  // for the downward case, each clamped to the target.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    next_value = current_value;
    up_sum     = {1'b0, current_value} + STEP_EXT;
    down_diff  = $signed({1'b0, current_value}) - $signed(STEP_EXT);
    if (current_value < target_value) begin
      if (up_sum >= {1'b0, target_value}) next_value = target_value;
      else                                next_value = up_sum[COEF_W-1:0];
    end else if (current_value > target_value) begin
      if (down_diff <= $signed({1'b0, target_value})) next_value = target_value;
      else                                            next_value = down_diff[COEF_W-1:0];
    end
    at_target = (next_value == target_value);
  end

endmodule

// File: rtl/coef_ramp_controller.sv
// Operator coefficient controller: button edges drive a saturating select,
// the select maps to a target, and the live coefficient slews toward the
// target one bounded step per sample strobe.
module coef_ramp_controller
  import coef_ramp_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              hold,
  input  logic              sample_strobe,
  output logic [SEL_W-1:0]  coefficient_select,
  output logic [COEF_W-1:0] coefficient,
  output logic [COEF_W-1:0] target,
  output logic              ramp_busy,
  output logic              coef_update
);

  logic              up_q;
  logic              down_q;
  logic              up_evt;
  logic              down_evt;
  logic [SEL_W-1:0]  sel_next;
  logic [COEF_W-1:0] target_next;
  logic [COEF_W-1:0] step_value;
  logic              step_at_target;
  logic              stepping;
  logic              landed;
  logic [COEF_W-1:0] coef_next;
  ramp_state_t       state;
  ramp_state_t       state_next;

  assign up_evt      = btn_up & ~up_q;
  assign down_evt    = btn_down & ~down_q;
  assign target      = coef_lookup(coefficient_select);
  assign target_next = coef_lookup(sel_next);
  assign ramp_busy   = (state == RAMP);

  coef_slew_step #(.STEP(STEP)) u_slew_step (
    .current_value (coefficient),
    .target_value  (target),
    .next_value    (step_value),
    .at_target     (step_at_target)
  );

  // Next select: one step per lone edge, saturating; simultaneous edges cancel.
  always_comb begin
    sel_next = coefficient_select;
    if (up_evt && !down_evt && coefficient_select != SEL_W'(7))
      sel_next = coefficient_select + SEL_W'(1);
    else if (down_evt && !up_evt && coefficient_select != SEL_W'(0))
      sel_next = coefficient_select - SEL_W'(1);
  end

  // Next ramp state: the FSM moves together with the target so that
  // ramp_busy always matches (coefficient != target).
  always_comb begin
    stepping = (state == RAMP) && sample_strobe && !hold;
    coef_next = stepping ? step_value : coefficient;
    landed    = stepping ? step_at_target : (state == IDLE);
    if (sel_next == coefficient_select)
      state_next = landed ? IDLE : RAMP;
    else
      state_next = (coef_next != target_next) ? RAMP : IDLE;
  end

  // Button history and select register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      up_q               <= 1'b0;
      down_q             <= 1'b0;
      coefficient_select <= '0;
    end else begin
      up_q               <= btn_up;
      down_q             <= btn_down;
      coefficient_select <= sel_next;
    end
  end

  // Ramp FSM with registered coefficient and update pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      coefficient <= '0;
      coef_update <= 1'b0;
    end else begin
      state       <= state_next;
      coefficient <= coef_next;
      coef_update <= (coef_next != coefficient);
    end
  end

endmodule
